mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Request-side controller that drives the team's single-port synchronous RAM (one port: we/addr/data in, registered data out, one-cycle read latency, write-first).
- Accepts single-word read/write and multi-word fill/copy commands from a client over a valid/ready handshake.
- Sequences the RAM port and returns read data with a one-cycle valid pulse.
- Sits between the datapath/CPU and the memory instance at top level.

Parameters:
ADDR_WIDTH, 6, RAM address width; all address arithmetic is modulo 2**ADDR_WIDTH.
DATA_WIDTH, 16, RAM word width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  client command valid
req_ready  output  1  controller can accept a command
req_op  input  2  00 READ, 01 WRITE, 10 FILL, 11 COPY
req_addr  input  ADDR_WIDTH  READ/WRITE address; FILL start; COPY source start
req_dst  input  ADDR_WIDTH  COPY destination start (ignored otherwise)
req_len  input  ADDR_WIDTH  FILL/COPY word count; 0 = no memory access
req_data  input  DATA_WIDTH  WRITE data / FILL pattern
rsp_valid  output  1  one-cycle pulse, rsp_data valid (READ only)
rsp_data  output  DATA_WIDTH  read result, held until next READ completes
done  output  1  one-cycle pulse when any command completes
mem_we  output  1  to RAM we
mem_addr  output  ADDR_WIDTH  to RAM addr
mem_data  output  DATA_WIDTH  to RAM data
mem_out  input  DATA_WIDTH  from RAM out

Behaviour:
- Reset (async, immediate): state IDLE, req_ready=1, rsp_valid=0, done=0, mem_we=0, mem_addr=0, mem_data=0, rsp_data=0, counters=0. mem_we must drop without waiting for a clock.
- Handshake: a command is accepted on a rising edge where req_valid&&req_ready. req_ready=1 only in IDLE. All req_* are sampled into registers at acceptance; later changes are ignored.
- mem_* and req_ready are decoded from registered state only; no combinational path from req_*.
- States: IDLE, RD, CAP, WR.
- READ:
  - acceptance edge E0 -> RD (mem_addr=addr, we=0).
  - E1: RAM samples -> CAP.
  - E2: rsp_data<=mem_out -> IDLE.
  - rsp_valid=done=1 for the one cycle after E2.
- WRITE: E0 -> WR (we=1, addr, data) for exactly one cycle -> IDLE. done pulses the cycle after WR.
- FILL len N:
  - WR held N cycles; mem_addr=start+i, i=0..N-1, data=pattern, we=1 every cycle.
  - done pulses the cycle after the last write.
- COPY len N, per word i:
  - RD (addr=src+i), then CAP (buf<=mem_out), then WR (addr=dst+i, data=buf, we=1). 3 cycles per word, 3N total.
  - Words are processed in ascending order, each read after the previous write. Overlap with dst>src therefore propagates source data forward; this is the defined behaviour.
- len=0 (FILL/COPY): no RAM access, we never asserted; done pulses the cycle after acceptance.
- Wrap-around: start+i wraps past 2**ADDR_WIDTH-1 to 0 with no error.
- done and rsp_valid coincide with IDLE, so a new command may be accepted in that same cycle (back-to-back).
- mem_we=0 in every state except WR.
- Reset mid-command: the command is abandoned and remaining words are not written. Words already written stay written.

Decomposition:
- Shared constants file mem_access_defs: op codes (OP_READ, OP_WRITE, OP_FILL, OP_COPY) and state encodings.
- No sub-module; a single flat module is natural. The address/length counter stays inline.
- Testbench instantiates the controller together with the RAM block.

Test Plan:
- WRITE addr 5 data 0x1234, then READ addr 5 -> one WR cycle with we=1; rsp_valid and done 2 cycles after READ acceptance, rsp_data=0x1234.
- FILL addr 62 len 4 data 0xAAAA -> writes to 62,63,0,1 on 4 consecutive cycles; done the next cycle; READs of all four return 0xAAAA, address 2 unchanged.
- Preload 0..2 = 0x11,0x22,0x33; COPY src 0 dst 10 len 3 -> 9 busy cycles; addresses 10..12 read back 0x11,0x22,0x33.
- COPY len 0 and FILL len 0 -> mem_we never high; done one cycle after acceptance; req_ready back the same cycle.
- Assert rst during word 2 of FILL addr 20 len 8 -> mem_we low immediately; outputs at reset values; addresses 20..21 written, 22..27 untouched.
- READ accepted in the same cycle as the previous READ's rsp_valid -> second rsp_valid exactly 2 cycles later, correct data.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared op codes and FSM state encodings for the RAM access controller.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_COPY  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_CAP  = 2'b10,
        ST_WR   = 2'b11
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Client command/response channel plus single-port RAM port of the access controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_dst;
    logic [ADDR_WIDTH-1:0] req_len;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  done;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_out;

    // Master is the client plus the RAM; slave is the controller.
    modport master (
        output req_valid, req_op, req_addr, req_dst, req_len, req_data, mem_out,
        input  req_ready, rsp_valid, rsp_data, done, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_dst, req_len, req_data, mem_out,
        output req_ready, rsp_valid, rsp_data, done, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences a single-port synchronous RAM for READ/WRITE/FILL/COPY commands
// accepted over a valid/ready handshake.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
        end
    end

    // WRITE and FILL share the WR path: dst_q is the write pointer for every op,
    // src_q the read pointer, cnt_q the words still to be written.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d   = op_e'(bus.req_op);
                    src_d  = bus.req_addr;
                    dst_d  = bus.req_addr;
                    data_d = bus.req_data;
                    cnt_d  = bus.req_len;
                    unique case (op_e'(bus.req_op))
                        OP_READ:  state_d = ST_RD;
                        OP_WRITE: begin
                            cnt_d   = ADDR_WIDTH'(1);
                            state_d = ST_WR;
                        end
                        OP_FILL: begin
                            if (bus.req_len == '0) done_d  = 1'b1;
                            else                   state_d = ST_WR;
                        end
                        OP_COPY: begin
                            dst_d = bus.req_dst;
                            if (bus.req_len == '0) done_d  = 1'b1;
                            else                   state_d = ST_RD;
                        end
                    endcase
                end
            end
            ST_RD: state_d = ST_CAP;
            ST_CAP: begin
                if (op_q == OP_READ) begin
                    rsp_data_d  = bus.mem_out;
                    rsp_valid_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    data_d  = bus.mem_out;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                cnt_d = cnt_q - ADDR_WIDTH'(1);
                src_d = src_q + ADDR_WIDTH'(1);
                dst_d = dst_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (op_q == OP_COPY) begin
                    state_d = ST_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM port is a pure decode of registered state, so mem_we falls with rst.
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.mem_we    = (state_q == ST_WR);
    assign bus.mem_addr  = (state_q == ST_WR) ? dst_q :
                           ((state_q == ST_RD) || (state_q == ST_CAP)) ? src_q : '0;
    assign bus.mem_data  = (state_q == ST_WR) ? data_q : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl driving a behavioural single-port RAM, with a write/read scoreboard.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_init = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Single-port RAM: registered output, one-cycle read latency, write-first.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(16'hC000 + i);
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_data;
        end
        bus.mem_out <= bus.mem_we ? bus.mem_data : ram[bus.mem_addr];
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        op_e           op;
        logic [AW-1:0] addr;
        logic [AW-1:0] dst;
        logic [AW-1:0] len;
        logic [DW-1:0] data;
        int            exp_lat;
        logic [DW-1:0] exp_rsp;
    } vec_t;

    logic [DW-1:0] model [DEPTH];
    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    vec_t          vecs[23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops expectations for whatever RAM write or read response the DUT shows this cycle.
    task automatic sample();
        wr_t           e;
        logic [DW-1:0] r;
        if (bus.mem_we) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, required no write", bus.mem_addr, bus.mem_data);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
                chk("wr_data", 32'(bus.mem_data), 32'(e.d));
            end
        end
        if (bus.rsp_valid) begin
            if (rq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: data 0x%0h, required no response", bus.rsp_data);
            end else begin
                r = rq.pop_front();
                chk("rsp_sb", 32'(bus.rsp_data), 32'(r));
            end
        end
    endtask

    task automatic push_model(input op_e op, input logic [AW-1:0] addr, input logic [AW-1:0] dst,
                              input logic [AW-1:0] len, input logic [DW-1:0] data);
        logic [AW-1:0] s, d;
        logic [DW-1:0] v;
        case (op)
            OP_READ: rq.push_back(model[addr]);
            OP_WRITE: begin
                wq.push_back('{addr, data});
                model[addr] = data;
            end
            OP_FILL: begin
                for (int i = 0; i < int'(len); i++) begin
                    d = AW'(int'(addr) + i);
                    wq.push_back('{d, data});
                    model[d] = data;
                end
            end
            OP_COPY: begin
                for (int i = 0; i < int'(len); i++) begin
                    s = AW'(int'(addr) + i);
                    d = AW'(int'(dst) + i);
                    v = model[s];
                    wq.push_back('{d, v});
                    model[d] = v;
                end
            end
        endcase
    endtask

    task automatic run_cmd(input op_e op, input logic [AW-1:0] addr, input logic [AW-1:0] dst,
                           input logic [AW-1:0] len, input logic [DW-1:0] data, input int exp_lat);
        int lat;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_dst   = dst;
        bus.req_len   = len;
        bus.req_data  = data;
        push_model(op, addr, dst, len, data);
        tick();
        // Scramble the request after acceptance; the DUT must have latched it.
        bus.req_valid = 1'b0;
        bus.req_op    = OP_COPY;
        bus.req_addr  = ~addr;
        bus.req_dst   = ~dst;
        bus.req_len   = len + 6'd7;
        bus.req_data  = ~data;
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            sample();
            if (bus.done) begin
                lat = k;
                break;
            end
            tick();
        end
        chk("done_latency", 32'(lat), 32'(exp_lat));
        chk("writes_drained", 32'(wq.size()), 32'd0);
        chk("reads_drained", 32'(rq.size()), 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = OP_READ;
        bus.req_addr  = '0;
        bus.req_dst   = '0;
        bus.req_len   = '0;
        bus.req_data  = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = DW'(16'hC000 + i);

        vecs[0]  = '{OP_WRITE, 6'd5,  6'd0,  6'd0, 16'h1234, 1, 16'h0000};
        vecs[1]  = '{OP_READ,  6'd5,  6'd0,  6'd0, 16'h0000, 2, 16'h1234};
        vecs[2]  = '{OP_FILL,  6'd62, 6'd0,  6'd4, 16'hAAAA, 4, 16'h0000};
        vecs[3]  = '{OP_READ,  6'd62, 6'd0,  6'd0, 16'h0000, 2, 16'hAAAA};
        vecs[4]  = '{OP_READ,  6'd63, 6'd0,  6'd0, 16'h0000, 2, 16'hAAAA};
        vecs[5]  = '{OP_READ,  6'd0,  6'd0,  6'd0, 16'h0000, 2, 16'hAAAA};
        vecs[6]  = '{OP_READ,  6'd1,  6'd0,  6'd0, 16'h0000, 2, 16'hAAAA};
        vecs[7]  = '{OP_READ,  6'd2,  6'd0,  6'd0, 16'h0000, 2, 16'hC002};
        vecs[8]  = '{OP_WRITE, 6'd0,  6'd0,  6'd0, 16'h0011, 1, 16'h0000};
        vecs[9]  = '{OP_WRITE, 6'd1,  6'd0,  6'd0, 16'h0022, 1, 16'h0000};
        vecs[10] = '{OP_WRITE, 6'd2,  6'd0,  6'd0, 16'h0033, 1, 16'h0000};
        vecs[11] = '{OP_COPY,  6'd0,  6'd10, 6'd3, 16'h0000, 9, 16'h0000};
        vecs[12] = '{OP_READ,  6'd10, 6'd0,  6'd0, 16'h0000, 2, 16'h0011};
        vecs[13] = '{OP_READ,  6'd11, 6'd0,  6'd0, 16'h0000, 2, 16'h0022};
        vecs[14] = '{OP_READ,  6'd12, 6'd0,  6'd0, 16'h0000, 2, 16'h0033};
        vecs[15] = '{OP_COPY,  6'd0,  6'd20, 6'd0, 16'h0000, 0, 16'h0000};
        vecs[16] = '{OP_FILL,  6'd30, 6'd0,  6'd0, 16'hFFFF, 0, 16'h0000};
        vecs[17] = '{OP_READ,  6'd30, 6'd0,  6'd0, 16'h0000, 2, 16'hC01E};
        vecs[18] = '{OP_COPY,  6'd0,  6'd1,  6'd2, 16'h0000, 6, 16'h0000};
        vecs[19] = '{OP_READ,  6'd2,  6'd0,  6'd0, 16'h0000, 2, 16'h0011};
        vecs[20] = '{OP_READ,  6'd1,  6'd0,  6'd0, 16'h0000, 2, 16'h0011};
        vecs[21] = '{OP_COPY,  6'd62, 6'd3,  6'd3, 16'h0000, 9, 16'h0000};
        vecs[22] = '{OP_READ,  6'd5,  6'd0,  6'd0, 16'h0000, 2, 16'h0011};

        ram_init = 1'b1;
        tick();
        ram_init = 1'b0;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_data",  32'(bus.mem_data),  32'd0);
        chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        rst = 1'b0;
        tick();

        // Commands issue back-to-back: each is presented in the previous one's done cycle.
        for (int v = 0; v < 23; v++) begin
            run_cmd(vecs[v].op, vecs[v].addr, vecs[v].dst, vecs[v].len, vecs[v].data, vecs[v].exp_lat);
            if (vecs[v].op == OP_READ) begin
                chk("tbl_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("tbl_rsp_data",  32'(bus.rsp_data),  32'(vecs[v].exp_rsp));
            end
        end

        // Reset while FILL 20 len 8 is presenting its third word (address 22).
        bus.req_valid = 1'b1;
        bus.req_op    = OP_FILL;
        bus.req_addr  = 6'd20;
        bus.req_dst   = 6'd0;
        bus.req_len   = 6'd8;
        bus.req_data  = 16'h5A5A;
        wq.push_back('{6'd20, 16'h5A5A});
        wq.push_back('{6'd21, 16'h5A5A});
        model[20] = 16'h5A5A;
        model[21] = 16'h5A5A;
        tick();
        bus.req_valid = 1'b0;
        sample();
        tick();
        sample();
        tick();
        chk("fill_w2_we",   32'(bus.mem_we),   32'd1);
        chk("fill_w2_addr", 32'(bus.mem_addr), 32'd22);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_done",      32'(bus.done),      32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("mid_rst_mem_data",  32'(bus.mem_data),  32'd0);
        chk("mid_rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_writes_drained", 32'(wq.size()), 32'd0);
        for (int a = 20; a < 28; a++) chk("ram_after_rst", 32'(ram[a]), 32'(model[a]));

        run_cmd(OP_READ, 6'd21, 6'd0, 6'd0, 16'h0000, 2);
        chk("post_rst_rd21", 32'(bus.rsp_data), 32'h5A5A);
        run_cmd(OP_READ, 6'd22, 6'd0, 6'd0, 16'h0000, 2);
        chk("post_rst_rd22", 32'(bus.rsp_data), 32'hC016);
        tick();
        chk("done_one_pulse", 32'(bus.done), 32'd0);
        chk("rsp_data_held",  32'(bus.rsp_data), 32'hC016);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
